coin_acceptor_encoder: RTL and testbench

//  Front-end coin acceptor that drives the coin_in bus of the vending FSM.

---
 rtl/coin_acceptor_encoder.sv | 107 ++++++++++
 tb/tb_coin_acceptor_encoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor_encoder.sv
// Coin acceptor front end: sync + debounce two coin sensors and queue
// each accepted coin as a single-cycle coin_in code for the vending FSM.
module coin_acceptor_encoder #(
  parameter int DEB_CYCLES = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_sig,
  input  logic                          reset,
  input  logic                          sense5,
  input  logic                          sense10,
  input  logic                          hold,
  output logic [1:0]                    coin_in,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] CNT_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

  // bit 0 = five-unit sensor, bit 1 = ten-unit sensor
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    deb;
  logic [1:0]    flip;
  logic [1:0]    rise;
  logic [DW-1:0] cnt [2];

  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] free_slots;
  logic          pop;
  logic          push5;
  logic          push10;
  logic          drop;

  always_ff @(posedge clk_sig) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {sense10, sense5};
      s2 <= s1;
    end
  end

  always_comb begin
    flip = '0;
    rise = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i] = (s2[i] != deb[i]) && (cnt[i] == CNT_MAX);
      rise[i] = flip[i] & s2[i];
    end
  end

  always_ff @(posedge clk_sig) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (flip[i]) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Room is judged on pre-edge occupancy, so a same-edge pop frees a slot.
  always_comb begin
    pop        = !hold && (fifo_count != '0);
    free_slots = DEPTH - fifo_count + CW'(pop);
    push5      = rise[0] && (free_slots != '0);
    push10     = rise[1] && (free_slots > CW'(push5));
    drop       = (rise[0] && !push5) || (rise[1] && !push10);
  end

  always_ff @(posedge clk_sig) begin
    if (push5) mem[wr_ptr] <= 2'b01;
    if (push10) mem[wr_ptr + PW'(push5)] <= 2'b10;
  end

  always_ff @(posedge clk_sig) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      coin_in    <= 2'b00;
      reject     <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(push5) + PW'(push10);
      rd_ptr     <= rd_ptr + PW'(pop);
      fifo_count <= fifo_count + CW'(push5) + CW'(push10) - CW'(pop);
      coin_in    <= pop ? mem[rd_ptr] : 2'b00;
      reject     <= drop;
    end
  end

endmodule

// File: tb/tb_coin_acceptor_encoder.sv
// Bench for coin_acceptor_encoder: directed scenarios plus random sensor
// traffic, every cycle compared against a window/queue reference model.
module tb_coin_acceptor_encoder;

  localparam int DEB   = 3;
  localparam int DEPTH = 4;

  logic       clk_sig = 1'b0;
  logic       reset;
  logic       sense5;
  logic       sense10;
  logic       hold;
  logic [1:0] coin_in;
  logic       reject;
  logic [2:0] fifo_count;

  coin_acceptor_encoder #(
    .DEB_CYCLES(DEB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_sig   (clk_sig),
    .reset     (reset),
    .sense5    (sense5),
    .sense10   (sense10),
    .hold      (hold),
    .coin_in   (coin_in),
    .reject    (reject),
    .fifo_count(fifo_count)
  );

  always #5 clk_sig = ~clk_sig;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         dl0 [2];
  bit         dl1 [2];
  bit         lvl [2];
  bit         win [2][DEB];
  int         nsamp [2];
  logic [1:0] fq [$];
  logic [1:0] m_coin;
  logic       m_rej;
  int         m_cnt;

  // per-scenario statistics
  int         rel;
  int         n5;
  int         n10;
  int         rej_n;
  int         first5;
  int         first10;
  logic [1:0] seq [$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit raw [2];
    bit ev [2];
    bit s2p;
    bit all_diff;
    raw[0] = sense5;
    raw[1] = sense10;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        dl0[i] = 0; dl1[i] = 0; lvl[i] = 0; nsamp[i] = 0;
      end
      fq.delete();
      m_coin = 2'b00;
      m_rej  = 1'b0;
      m_cnt  = 0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      s2p = dl1[i];
      dl1[i] = dl0[i];
      dl0[i] = raw[i];
      for (int k = DEB - 1; k > 0; k--) win[i][k] = win[i][k-1];
      win[i][0] = s2p;
      if (nsamp[i] < DEB) nsamp[i]++;
      ev[i] = 0;
      if (nsamp[i] == DEB) begin
        all_diff = 1;
        for (int k = 0; k < DEB; k++)
          if (win[i][k] == lvl[i]) all_diff = 0;
        if (all_diff) begin
          lvl[i] = !lvl[i];
          ev[i]  = lvl[i];
        end
      end
    end
    m_coin = 2'b00;
    if (!hold && fq.size() > 0) m_coin = fq.pop_front();
    m_rej = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) begin
        if (fq.size() < DEPTH) fq.push_back(i == 0 ? 2'b01 : 2'b10);
        else m_rej = 1'b1;
      end
    end
    m_cnt = fq.size();
  endtask

  task automatic tick();
    int idx;
    @(posedge clk_sig);
    model_step();
    #1;
    check("coin_in", 32'(coin_in), 32'(m_coin));
    check("reject", 32'(reject), 32'(m_rej));
    check("fifo_count", 32'(fifo_count), 32'(m_cnt));
    idx = rel;
    rel++;
    if (coin_in == 2'b01) begin
      n5++;
      if (first5 < 0) first5 = idx;
    end
    if (coin_in == 2'b10) begin
      n10++;
      if (first10 < 0) first10 = idx;
    end
    if (coin_in != 2'b00) seq.push_back(coin_in);
    if (reject) rej_n++;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic clear_stats();
    rel = 0; n5 = 0; n10 = 0; rej_n = 0;
    first5 = -1; first10 = -1;
    seq.delete();
  endtask

  task automatic coin(bit ten, int hi, int lo);
    if (ten) sense10 = 1'b1;
    else sense5 = 1'b1;
    run(hi);
    sense5  = 1'b0;
    sense10 = 1'b0;
    run(lo);
  endtask

  initial begin
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10;
    exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    reset = 1'b1; sense5 = 1'b0; sense10 = 1'b0; hold = 1'b0;
    clear_stats();
    run(2);
    check("rst_coin", 32'(coin_in), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    run(3);

    // 1: single five, latency
    clear_stats();
    coin(1'b0, 10, 10);
    check("t1_latency", first5, 5);
    check("t1_n5", n5, 1);
    check("t1_reject", rej_n, 0);
    check("t1_count", 32'(fifo_count), 32'd0);

    // 2: short glitch ignored
    clear_stats();
    coin(1'b1, 2, 10);
    check("t2_n10", n10, 0);
    check("t2_count", 32'(fifo_count), 32'd0);

    // 3: both sensors together
    clear_stats();
    sense5 = 1'b1; sense10 = 1'b1;
    run(10);
    sense5 = 1'b0; sense10 = 1'b0;
    run(10);
    check("t3_first5", first5, 5);
    check("t3_first10", first10, 6);
    check("t3_n", n5 + n10, 2);

    // 4: overflow under hold, then drain
    clear_stats();
    hold = 1'b1;
    for (int c = 0; c < 5; c++) coin(c[0], 5, 8);
    check("t4_count", 32'(fifo_count), 32'd4);
    check("t4_rejects", rej_n, 1);
    check("t4_none_issued", n5 + n10, 0);
    clear_stats();
    hold = 1'b0;
    run(8);
    check("t4_seq_len", seq.size(), 4);
    if (seq.size() == 4)
      for (int k = 0; k < 4; k++) check("t4_seq", 32'(seq[k]), 32'(exp_seq[k]));
    check("t4_b2b_first", first5, 0);
    check("t4_b2b_ten", first10, 1);

    // 5: reset discards queued coins
    hold = 1'b1;
    for (int c = 0; c < 3; c++) coin(1'b0, 5, 8);
    check("t5_count", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    run(1);
    check("t5_rst_count", 32'(fifo_count), 32'd0);
    check("t5_rst_coin", 32'(coin_in), 32'd0);
    reset = 1'b0; hold = 1'b0;
    clear_stats();
    run(12);
    check("t5_no_issue", n5 + n10, 0);

    // 6: sensor held across reset counts once
    sense10 = 1'b1;
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    clear_stats();
    run(12);
    sense10 = 1'b0;
    run(10);
    check("t6_latency", first10, 5);
    check("t6_n10", n10, 1);

    // random traffic
    for (int s = 0; s < 70; s++) begin
      sense5  = 1'($urandom_range(0, 1));
      sense10 = 1'($urandom_range(0, 1));
      hold    = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 39) == 0);
      run($urandom_range(1, 8));
    end
    reset = 1'b0; hold = 1'b0; sense5 = 1'b0; sense10 = 1'b0;
    run(20);
    check("drain_count", 32'(fifo_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
